// File: rtl/ped_button_conditioner.sv
// Pedestrian push-button conditioner: synchronizer, debouncer, press detector,
// request latch with acknowledge-driven hold-off, and a saturating press counter.
module ped_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLDOFF_CYCLES  = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       ack,
  output logic       button,
  output logic       holdoff,
  output logic       btn_db,
  output logic       press_pulse,
  output logic [7:0] press_count
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DZERO = DW'(0);
  localparam logic [DW-1:0] DONE  = DW'(1);
  localparam logic [HW-1:0] HLAST = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [HW-1:0] HZERO = HW'(0);
  localparam logic [HW-1:0] HONE  = HW'(1);

  // Encoding chosen so each output is a single state flop.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    HOLDOFF = 2'b10
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            sync1;
  logic            btn_sync;
  logic [DW-1:0]   dcnt;
  logic            btn_db_d;
  logic            press_evt;
  logic            hold_done;
  logic [HW-1:0]   hcnt;

  // Two-flop synchronizer for the asynchronous raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sync1    <= btn_raw;
      btn_sync <= sync1;
    end
  end

  // Debouncer: the level must disagree for DEBOUNCE_CYCLES consecutive edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt   <= DZERO;
      btn_db <= 1'b0;
    end else if (btn_sync != btn_db) begin
      if (dcnt == DLAST) begin
        btn_db <= ~btn_db;
        dcnt   <= DZERO;
      end else begin
        btn_db <= btn_db;
        dcnt   <= dcnt + DONE;
      end
    end else begin
      btn_db <= btn_db;
      dcnt   <= DZERO;
    end
  end

  // Rising-edge detect on the debounced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db_d <= 1'b0;
    end else begin
      btn_db_d <= btn_db;
    end
  end

  // Press event is acted on by the FSM and counter at the same edge press_pulse rises.
  always_comb begin
    press_evt = btn_db & ~btn_db_d;
    hold_done = (hcnt == HLAST);
  end

  // Registered one-cycle press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= press_evt;
    end
  end

  // Saturating press counter, counts in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_count <= 8'd0;
    end else if (press_evt && (press_count != 8'd255)) begin
      press_count <= press_count + 8'd1;
    end else begin
      press_count <= press_count;
    end
  end

  // Hold-off counter, reloaded when the pending request is acknowledged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= HZERO;
    end else if ((state == PENDING) && ack) begin
      hcnt <= HZERO;
    end else if ((state == HOLDOFF) && !hold_done) begin
      hcnt <= hcnt + HONE;
    end else begin
      hcnt <= hcnt;
    end
  end

  // Request FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request FSM next-state logic; only IDLE latches a press.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (press_evt) begin
          state_next = PENDING;
        end else begin
          state_next = IDLE;
        end
      end
      PENDING: begin
        if (ack) begin
          state_next = HOLDOFF;
        end else begin
          state_next = PENDING;
        end
      end
      HOLDOFF: begin
        if (hold_done) begin
          state_next = IDLE;
        end else begin
          state_next = HOLDOFF;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign button  = state[0];
  assign holdoff = state[1];

endmodule

// File: tb/tb_ped_button_conditioner.sv
// Self-checking bench for ped_button_conditioner: an edge-indexed history model
// compared every cycle, plus hand-computed checkpoints from the test plan.
module tb_ped_button_conditioner;

  localparam int D = 4;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw = 1'b0;
  logic       ack = 1'b0;
  logic       button;
  logic       holdoff;
  logic       btn_db;
  logic       press_pulse;
  logic [7:0] press_count;

  int total = 0;
  int bad = 0;

  ped_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLDOFF_CYCLES (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .ack        (ack),
    .button     (button),
    .holdoff    (holdoff),
    .btn_db     (btn_db),
    .press_pulse(press_pulse),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Model state: edges since reset release, raw sample history, derived results.
  int mk;
  bit raw_hist[$];
  bit m_db;
  int last_tog;
  bit db_rose;
  bit m_pulse;
  bit m_pend;
  bit m_hold;
  int hold_until;
  int m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mk = 0;
      raw_hist.delete();
      m_db = 1'b0;
      last_tog = -1;
      db_rose = 1'b0;
      m_pulse = 1'b0;
      m_pend = 1'b0;
      m_hold = 1'b0;
      hold_until = -1;
      m_cnt = 0;
    end else begin
      bit press_now;
      bit tog;
      bit sp;
      press_now = db_rose;
      raw_hist.push_back(btn_raw);
      // level flips once the synchronized input disagreed on the last D edges since the previous flip
      tog = 1'b1;
      for (int j = mk - D + 1; j <= mk; j++) begin
        if (j <= last_tog) begin
          tog = 1'b0;
        end else begin
          sp = (j >= 2) ? raw_hist[j-2] : 1'b0;
          if (sp == m_db) tog = 1'b0;
        end
      end
      db_rose = tog && !m_db;
      if (tog) begin
        m_db = !m_db;
        last_tog = mk;
      end
      m_pulse = press_now;
      if (press_now && m_cnt < 255) m_cnt = m_cnt + 1;
      if (m_pend) begin
        if (ack) begin
          m_pend = 1'b0;
          hold_until = mk + H;
        end
      end else if (mk > hold_until) begin
        if (press_now) m_pend = 1'b1;
      end
      m_hold = (mk < hold_until);
      mk = mk + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      cmp("cyc_btn_db", int'(btn_db), int'(m_db));
      cmp("cyc_press_pulse", int'(press_pulse), int'(m_pulse));
      cmp("cyc_button", int'(button), int'(m_pend));
      cmp("cyc_holdoff", int'(holdoff), int'(m_hold));
      cmp("cyc_press_count", int'(press_count), m_cnt);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cycles(3);
    rst = 1'b0;
    cmp("reset_button", int'(button), 0);
    cmp("reset_holdoff", int'(holdoff), 0);
    cmp("reset_count", int'(press_count), 0);
    cycles(2);

    // Bounce: 2-cycle runs never survive a 4-cycle debounce.
    for (int i = 0; i < 20; i++) begin
      btn_raw = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
      cycles(1);
    end
    btn_raw = 1'b0;
    cycles(10);
    cmp("bounce_db", int'(btn_db), 0);
    cmp("bounce_button", int'(button), 0);
    cmp("bounce_count", int'(press_count), 0);

    // Clean press: btn_db after edge 5, pulse and button after edge 6.
    btn_raw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycles(1);
      if (k == 4) cmp("t1_db_e4", int'(btn_db), 0);
      if (k == 5) begin
        cmp("t1_db_e5", int'(btn_db), 1);
        cmp("t1_pulse_e5", int'(press_pulse), 0);
        cmp("t1_button_e5", int'(button), 0);
      end
      if (k == 6) begin
        cmp("t1_pulse_e6", int'(press_pulse), 1);
        cmp("t1_button_e6", int'(button), 1);
        cmp("t1_count_e6", int'(press_count), 1);
      end
      if (k == 7) cmp("t1_pulse_e7", int'(press_pulse), 0);
    end
    btn_raw = 1'b0;
    cycles(10);
    cmp("release_db", int'(btn_db), 0);
    cmp("release_button_held", int'(button), 1);

    // Ack at edge N, then a press completing at edge N+7 inside hold-off.
    ack = 1'b1;
    cycles(1);
    ack = 1'b0;
    cmp("t3_button_n", int'(button), 0);
    cmp("t3_holdoff_n", int'(holdoff), 1);
    btn_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycles(1);
      if (k == 7) begin
        cmp("t3_pulse_n7", int'(press_pulse), 1);
        cmp("t3_count_n7", int'(press_count), 2);
        cmp("t3_holdoff_n7", int'(holdoff), 1);
        cmp("t3_button_n7", int'(button), 0);
      end
      if (k == 8) begin
        cmp("t3_holdoff_n8", int'(holdoff), 0);
        cmp("t3_button_n8", int'(button), 0);
      end
    end
    btn_raw = 1'b0;
    cycles(12);

    // Ack alone in IDLE changes nothing.
    ack = 1'b1;
    cycles(1);
    ack = 1'b0;
    cmp("t4_idle_ack_button", int'(button), 0);
    cmp("t4_idle_ack_holdoff", int'(holdoff), 0);

    // Get to PENDING, then a press whose edge coincides with ack.
    btn_raw = 1'b1;
    cycles(7);
    btn_raw = 1'b0;
    cycles(10);
    cmp("t4_pending", int'(button), 1);
    cmp("t4_count_before", int'(press_count), 3);
    btn_raw = 1'b1;
    cycles(6);
    ack = 1'b1;
    cycles(1);
    ack = 1'b0;
    cmp("t4_sim_pulse", int'(press_pulse), 1);
    cmp("t4_sim_button", int'(button), 0);
    cmp("t4_sim_holdoff", int'(holdoff), 1);
    cmp("t4_sim_count", int'(press_count), 4);
    btn_raw = 1'b0;
    cycles(H + 8);

    // 300 acknowledged presses: count saturates at 255 and stays there.
    for (int i = 0; i < 300; i++) begin
      btn_raw = 1'b1;
      cycles(7);
      ack = 1'b1;
      cycles(1);
      ack = 1'b0;
      btn_raw = 1'b0;
      cycles(10);
      if (i == 250) cmp("t5_count_reach", int'(press_count), 255);
    end
    cmp("t5_count_sat", int'(press_count), 255);
    cmp("t5_button", int'(button), 0);

    // Asynchronous reset mid-PENDING, button held through release.
    btn_raw = 1'b1;
    cycles(7);
    cmp("t6_pending", int'(button), 1);
    #2;
    rst = 1'b1;
    #1;
    cmp("t6_rst_button", int'(button), 0);
    cmp("t6_rst_db", int'(btn_db), 0);
    cmp("t6_rst_count", int'(press_count), 0);
    cmp("t6_rst_holdoff", int'(holdoff), 0);
    cycles(2);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cycles(1);
      if (k == 5) begin
        cmp("t6_db_e5", int'(btn_db), 1);
        cmp("t6_button_e5", int'(button), 0);
      end
      if (k == 6) begin
        cmp("t6_pulse_e6", int'(press_pulse), 1);
        cmp("t6_button_e6", int'(button), 1);
        cmp("t6_count_e6", int'(press_count), 1);
      end
    end
    btn_raw = 1'b0;
    cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
